// File: rtl/pcie_ltssm_monitor_if.sv
// Status bus between the PCIe LTSSM monitor and its consumers (LED logic, stats readout).
// Optional history ports exist only when LTSSM_HISTORY_EN is defined.
interface pcie_ltssm_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic [63:0]      test_out_icm;
  logic             clr_stats;
  logic [1:0]       link_state;
  logic             link_up;
  logic [4:0]       ltssm_q;
  logic [CNT_W-1:0] linkdown_cnt;
  logic             train_timeout;
  logic             L0_led;
  logic             comp_led;
  logic             alive_led;
`ifdef LTSSM_HISTORY_EN
  logic             hist_pop;
  logic             hist_valid;
  logic [4:0]       hist_data;
  logic             hist_ovf;

  modport master (
    output test_out_icm, clr_stats, hist_pop,
    input  link_state, link_up, ltssm_q, linkdown_cnt, train_timeout,
           L0_led, comp_led, alive_led, hist_valid, hist_data, hist_ovf
  );
  modport slave (
    input  test_out_icm, clr_stats, hist_pop,
    output link_state, link_up, ltssm_q, linkdown_cnt, train_timeout,
           L0_led, comp_led, alive_led, hist_valid, hist_data, hist_ovf
  );
`else
  modport master (
    output test_out_icm, clr_stats,
    input  link_state, link_up, ltssm_q, linkdown_cnt, train_timeout,
           L0_led, comp_led, alive_led
  );
  modport slave (
    input  test_out_icm, clr_stats,
    output link_state, link_up, ltssm_q, linkdown_cnt, train_timeout,
           L0_led, comp_led, alive_led
  );
`endif
endinterface

// File: rtl/pcie_ltssm_monitor.sv
// Debounces the hard IP LTSSM code into link status, LEDs and link-health statistics.
// Optional LTSSM history FIFO enabled by defining LTSSM_HISTORY_EN.
module pcie_ltssm_monitor #(
  parameter int unsigned STABLE_CYC    = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned TRAIN_TIMEOUT = 125000,
  parameter int unsigned ALIVE_BIT     = 24,
  parameter int unsigned HIST_DEPTH    = 8
) (
  input  logic                  clk125,
  input  logic                  pcie_rstn,
  pcie_ltssm_monitor_if.slave   mon
);

  localparam int unsigned DBC_W   = $clog2(STABLE_CYC) + 1;
  localparam int unsigned TMR_W   = $clog2(TRAIN_TIMEOUT) + 1;
  localparam int unsigned ALIVE_W = ALIVE_BIT + 1;
  localparam logic [DBC_W-1:0] DBC_MAX = DBC_W'(STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_DOWN  = 2'b00,
    ST_TRAIN = 2'b01,
    ST_UP    = 2'b10,
    ST_RECOV = 2'b11
  } state_t;

  logic [4:0]         sync1, sync2, cand, ltssm_q_r;
  logic [DBC_W-1:0]   dbc_cnt;
  logic               q_upd_c;
  logic [58:0]        unused_test_out;

  state_t             state, state_n;
  logic               cnt_inc_c, tmr_run_c;
  logic               is_det_c, is_l0_c, is_rec_c;
  logic [TMR_W-1:0]   train_tmr;
  logic [CNT_W-1:0]   linkdown_cnt_r;
  logic               train_timeout_r, link_up_r, l0_led_r, comp_led_r;
  logic [ALIVE_W-1:0] alive_cnt;

  assign unused_test_out = mon.test_out_icm[63:5];

  // Only a value change counts as an update; the saturated counter keeps the compare true.
  assign q_upd_c = (cand == sync2) && (dbc_cnt == DBC_MAX) && (cand != ltssm_q_r);

  // Two-flop synchronizer followed by the stability filter
  always_ff @(posedge clk125 or negedge pcie_rstn) begin
    if (!pcie_rstn) begin
      sync1     <= 5'h00;
      sync2     <= 5'h00;
      cand      <= 5'h00;
      dbc_cnt   <= '0;
      ltssm_q_r <= 5'h00;
    end else begin
      sync1 <= mon.test_out_icm[4:0];
      sync2 <= sync1;
      if (cand != sync2) begin
        cand    <= sync2;
        dbc_cnt <= '0;
      end else if (dbc_cnt != DBC_MAX) begin
        dbc_cnt <= dbc_cnt + DBC_W'(1);
      end
      if (q_upd_c) ltssm_q_r <= cand;
    end
  end

  assign is_det_c = (ltssm_q_r == 5'h00) || (ltssm_q_r == 5'h01);
  assign is_l0_c  = (ltssm_q_r == 5'h0F);
  assign is_rec_c = (ltssm_q_r >= 5'h0C) && (ltssm_q_r <= 5'h0E);

  always_ff @(posedge clk125 or negedge pcie_rstn) begin
    if (!pcie_rstn) state <= ST_DOWN;
    else            state <= state_n;
  end

  // Link FSM: losing the link from UP/RECOV bumps the link-down counter
  always_comb begin
    state_n   = state;
    cnt_inc_c = 1'b0;
    tmr_run_c = 1'b0;
    case (state)
      ST_DOWN: begin
        if (is_l0_c)        state_n = ST_UP;
        else if (!is_det_c) state_n = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (is_l0_c)       state_n = ST_UP;
        else if (is_det_c) state_n = ST_DOWN;
        else               tmr_run_c = 1'b1;
      end
      ST_UP: begin
        if (is_rec_c) begin
          state_n = ST_RECOV;
        end else if (is_det_c) begin
          state_n   = ST_DOWN;
          cnt_inc_c = 1'b1;
        end else if (!is_l0_c) begin
          state_n   = ST_TRAIN;
          cnt_inc_c = 1'b1;
        end
      end
      ST_RECOV: begin
        if (is_l0_c) begin
          state_n = ST_UP;
        end else if (is_det_c) begin
          state_n   = ST_DOWN;
          cnt_inc_c = 1'b1;
        end else if (!is_rec_c) begin
          state_n   = ST_TRAIN;
          cnt_inc_c = 1'b1;
        end
      end
      default: state_n = ST_DOWN;
    endcase
  end

  // Statistics, training watchdog, LEDs and heartbeat
  always_ff @(posedge clk125 or negedge pcie_rstn) begin
    if (!pcie_rstn) begin
      train_tmr       <= '0;
      train_timeout_r <= 1'b0;
      linkdown_cnt_r  <= '0;
      link_up_r       <= 1'b0;
      l0_led_r        <= 1'b1;
      comp_led_r      <= 1'b1;
      alive_cnt       <= '0;
    end else begin
      if (!tmr_run_c)                 train_tmr <= '0;
      else if (train_tmr != TMR_MAX)  train_tmr <= train_tmr + TMR_W'(1);

      if (mon.clr_stats)                           train_timeout_r <= 1'b0;
      else if (tmr_run_c && train_tmr == TMR_MAX)  train_timeout_r <= 1'b1;

      if (mon.clr_stats)                        linkdown_cnt_r <= '0;
      else if (cnt_inc_c && !(&linkdown_cnt_r)) linkdown_cnt_r <= linkdown_cnt_r + CNT_W'(1);

      link_up_r  <= (state_n == ST_UP);
      l0_led_r   <= (ltssm_q_r != 5'h0F);
      comp_led_r <= (ltssm_q_r != 5'h03);
      alive_cnt  <= alive_cnt + ALIVE_W'(1);
    end
  end

  assign mon.link_state    = state;
  assign mon.link_up       = link_up_r;
  assign mon.ltssm_q       = ltssm_q_r;
  assign mon.linkdown_cnt  = linkdown_cnt_r;
  assign mon.train_timeout = train_timeout_r;
  assign mon.L0_led        = l0_led_r;
  assign mon.comp_led      = comp_led_r;
  assign mon.alive_led     = alive_cnt[ALIVE_BIT];

`ifdef LTSSM_HISTORY_EN
  localparam int unsigned HP_W = $clog2(HIST_DEPTH);
  localparam int unsigned HC_W = HP_W + 1;

  logic [4:0]      hist_mem [HIST_DEPTH];
  logic [HP_W-1:0] wr_ptr, rd_ptr;
  logic [HC_W-1:0] hist_cnt;
  logic            hist_ovf_r, hist_full_c, hist_push_c, hist_pop_c;

  assign hist_full_c = (hist_cnt == HC_W'(HIST_DEPTH));
  assign hist_pop_c  = mon.hist_pop && (hist_cnt != '0);
  // A same-cycle pop frees the slot, so a push into a full FIFO is not dropped then
  assign hist_push_c = q_upd_c && (!hist_full_c || hist_pop_c);

  always_ff @(posedge clk125 or negedge pcie_rstn) begin
    if (!pcie_rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hist_cnt   <= '0;
      hist_ovf_r <= 1'b0;
    end else begin
      if (hist_push_c) wr_ptr <= wr_ptr + HP_W'(1);
      if (hist_pop_c)  rd_ptr <= rd_ptr + HP_W'(1);
      if (hist_push_c && !hist_pop_c)      hist_cnt <= hist_cnt + HC_W'(1);
      else if (!hist_push_c && hist_pop_c) hist_cnt <= hist_cnt - HC_W'(1);
      if (mon.clr_stats)                                  hist_ovf_r <= 1'b0;
      else if (q_upd_c && hist_full_c && !hist_pop_c)     hist_ovf_r <= 1'b1;
    end
  end

  always_ff @(posedge clk125) begin
    if (hist_push_c) hist_mem[wr_ptr] <= cand;
  end

  assign mon.hist_valid = (hist_cnt != '0);
  assign mon.hist_data  = (hist_cnt != '0) ? hist_mem[rd_ptr] : 5'h00;
  assign mon.hist_ovf   = hist_ovf_r;
`endif

endmodule

// File: tb/tb_pcie_ltssm_monitor.sv
// Scoreboard bench for pcie_ltssm_monitor: stimulus queues expected status snapshots,
// a negedge monitor pops one per observed status change and checks value and latency.
`timescale 1ns/1ps
module tb_pcie_ltssm_monitor;
  localparam int unsigned STABLE_CYC    = 4;
  localparam int unsigned CNT_W         = 3;
  localparam int unsigned TRAIN_TIMEOUT = 100;
  localparam int unsigned ALIVE_BIT     = 3;
  localparam int unsigned HIST_DEPTH    = 8;
  localparam int unsigned ST_W          = CNT_W + 6;
  localparam int          LAT           = 2 + STABLE_CYC + 1;
  localparam int          CNT_MAX       = (1 << CNT_W) - 1;

  logic clk125    = 1'b0;
  logic pcie_rstn = 1'b0;

  pcie_ltssm_monitor_if #(.CNT_W(CNT_W)) bus ();

  pcie_ltssm_monitor #(
    .STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W), .TRAIN_TIMEOUT(TRAIN_TIMEOUT),
    .ALIVE_BIT(ALIVE_BIT), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .clk125(clk125),
    .pcie_rstn(pcie_rstn),
    .mon(bus)
  );

  always #4 clk125 = ~clk125;

  typedef struct {
    logic [ST_W-1:0] st;
    int              lat;
    string           name;
  } exp_t;

  exp_t        expq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          mark   = 0;
  int unsigned alive_m = 0;
  logic [ST_W-1:0] prev_st;
  logic [ST_W-1:0] cur_st;

  always @(posedge clk125) cyc <= cyc + 1;

  always @(posedge clk125 or negedge pcie_rstn) begin
    if (!pcie_rstn) alive_m <= 0;
    else            alive_m <= alive_m + 1;
  end

  function automatic logic [ST_W-1:0] mk(input logic [1:0] ls, input logic up, input int cnt,
                                         input logic tt, input logic l0, input logic comp);
    return {ls, up, CNT_W'(cnt), tt, l0, comp};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input string name, input logic [ST_W-1:0] st, input int lat);
    exp_t e;
    e.name = name;
    e.st   = st;
    e.lat  = lat;
    expq.push_back(e);
  endtask

  task automatic drive_code(input logic [4:0] c);
    bus.test_out_icm      = {$urandom(), $urandom()};
    bus.test_out_icm[4:0] = c;
    mark = cyc + 1;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk125);
  endtask

  task automatic pulse_clr();
    bus.clr_stats = 1'b1;
    mark = cyc + 1;
    @(negedge clk125);
    bus.clr_stats = 1'b0;
  endtask

  // Monitor: every status change must match the next queued expectation
  always @(negedge clk125) begin
    exp_t e;
    cur_st = {bus.link_state, bus.link_up, bus.linkdown_cnt, bus.train_timeout,
              bus.L0_led, bus.comp_led};
    chk("alive_led", 64'(bus.alive_led), 64'(alive_m[ALIVE_BIT]));
    if (cur_st !== prev_st) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: got %0h with nothing expected (t=%0t)", cur_st, $time);
      end else begin
        e = expq.pop_front();
        chk(e.name, 64'(cur_st), 64'(e.st));
        if (e.lat >= 0) chk({e.name, "_latency"}, 64'(cyc - mark), 64'(e.lat));
      end
      prev_st = cur_st;
    end
  end

  initial begin
    int n;
    bus.test_out_icm = '0;
    bus.clr_stats    = 1'b0;
`ifdef LTSSM_HISTORY_EN
    bus.hist_pop     = 1'b0;
`endif
    push_exp("reset", mk(2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b1), -1);
    hold(3);
    pcie_rstn = 1'b1;
    hold(10);

    // Bring-up: OTH codes train, L0 brings the link up
    push_exp("train_on_02", mk(2'd1, 1'b0, 0, 1'b0, 1'b1, 1'b1), LAT);
    drive_code(5'h02); hold(20);
    drive_code(5'h04); hold(20);
    push_exp("up_on_0f", mk(2'd2, 1'b1, 0, 1'b0, 1'b0, 1'b1), LAT);
    drive_code(5'h0F); hold(20);

    // Short recovery glitch is filtered; a held one enters RECOV without counting
    drive_code(5'h0C); hold(2);
    drive_code(5'h0F); hold(20);
    push_exp("recov_on_0c", mk(2'd3, 1'b0, 0, 1'b0, 1'b1, 1'b1), LAT);
    drive_code(5'h0C); hold(10);
    drive_code(5'h0E); hold(10);
    push_exp("up_from_recov", mk(2'd2, 1'b1, 0, 1'b0, 1'b0, 1'b1), LAT);
    drive_code(5'h0F); hold(20);

    // Link-down counting up to saturation
    for (int i = 1; i <= CNT_MAX + 1; i++) begin
      int c;
      c = (i < CNT_MAX) ? i : CNT_MAX;
      if (i == 1) begin
        push_exp("up_to_train", mk(2'd1, 1'b0, c, 1'b0, 1'b1, 1'b1), LAT);
        drive_code(5'h02);
      end else begin
        push_exp("up_to_down", mk(2'd0, 1'b0, c, 1'b0, 1'b1, 1'b1), LAT);
        drive_code(5'h00);
      end
      hold(20);
      push_exp("relink_up", mk(2'd2, 1'b1, c, 1'b0, 1'b0, 1'b1), LAT);
      drive_code(5'h0F); hold(20);
    end
    push_exp("clr_cnt", mk(2'd2, 1'b1, 0, 1'b0, 1'b0, 1'b1), 0);
    pulse_clr(); hold(5);

    // Compliance LED and training watchdog
    push_exp("train_on_03", mk(2'd1, 1'b0, 1, 1'b0, 1'b1, 1'b0), LAT);
    drive_code(5'h03); hold(20);
    push_exp("comp_led_off", mk(2'd1, 1'b0, 1, 1'b0, 1'b1, 1'b1), LAT);
    push_exp("train_timeout", mk(2'd1, 1'b0, 1, 1'b1, 1'b1, 1'b1), -1);
    drive_code(5'h02); hold(TRAIN_TIMEOUT + 10);
    push_exp("up_keeps_timeout", mk(2'd2, 1'b1, 1, 1'b1, 1'b0, 1'b1), LAT);
    drive_code(5'h0F); hold(20);
    push_exp("clr_timeout", mk(2'd2, 1'b1, 0, 1'b0, 1'b0, 1'b1), 0);
    pulse_clr(); hold(5);

    // clr_stats on the very edge the link drops: clear wins over the increment
    push_exp("clr_beats_inc", mk(2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b1), LAT);
    drive_code(5'h00);
    hold(7);
    bus.clr_stats = 1'b1;
    @(negedge clk125);
    bus.clr_stats = 1'b0;
    hold(20);

`ifdef LTSSM_HISTORY_EN
    begin : hist_blk
      logic [4:0] hexp[$];
      logic [4:0] hc;
      pulse_clr();
      n = 0;
      while (bus.hist_valid && n < 64) begin
        bus.hist_pop = 1'b1;
        @(negedge clk125);
        n++;
      end
      bus.hist_pop = 1'b0;
      chk("hist_drained", 64'(bus.hist_valid), 64'(0));
      for (int i = 0; i < 9; i++) begin
        hc = (i % 2 == 0) ? 5'h01 : 5'h00;
        drive_code(hc); hold(10);
        if (i < 8) hexp.push_back(hc);
      end
      chk("hist_ovf", 64'(bus.hist_ovf), 64'(1));
      for (int i = 0; i < 8; i++) begin
        chk("hist_valid", 64'(bus.hist_valid), 64'(1));
        chk("hist_data", 64'(bus.hist_data), 64'(hexp[i]));
        bus.hist_pop = 1'b1;
        @(negedge clk125);
        bus.hist_pop = 1'b0;
      end
      chk("hist_empty", 64'(bus.hist_valid), 64'(0));
      chk("hist_data_empty", 64'(bus.hist_data), 64'(0));
    end
`endif

    // Asynchronous reset while the link is up
    push_exp("up_before_reset", mk(2'd2, 1'b1, 0, 1'b0, 1'b0, 1'b1), LAT);
    drive_code(5'h0F); hold(20);
    push_exp("async_reset", mk(2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b1), -1);
    @(posedge clk125);
    #2;
    pcie_rstn = 1'b0;
    @(negedge clk125);
    drive_code(5'h00);
    hold(3);
    pcie_rstn = 1'b1;
    hold(20);

    n = 0;
    while (expq.size() != 0 && n < 50) begin
      hold(1);
      n++;
    end
    chk("expectations_consumed", 64'(expq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
